ps2_tx: RTL

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Drives the open-drain keyboard clock and data lines through active-high pull-low enables.
- Sits beside the keyboard receiver on the same clock_key/data_key pins.
- Runs entirely in the clock_fpga domain. Keyboard lines are synchronised internally.

---
 rtl/ps2_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device over the open-drain clock/data pair. The pins are
// driven through active-high pull-low enables, and all timing is taken from clock_fpga. The
// device-generated keyboard clock and data are resynchronised before use.
module ps2_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clock_fpga,
   input  logic       reset,
   input  logic       clock_key,
   input  logic       data_key,
   input  logic [7:0] data_in,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       clock_key_oe,
   output logic       data_key_oe
);

   // One counter serves both the inhibit hold and the frame timeout, so size it for the larger.
   localparam int unsigned MaxCount = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                          : INHIBIT_CYCLES;
   localparam int unsigned TimerW   = $clog2(MaxCount + 1);

   localparam logic [TimerW-1:0] InhibitLast = TimerW'(INHIBIT_CYCLES - 1);
   localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

   // Frame is {stop, parity, data[7:0], start}; bit 0 is the bit currently on the wire.
   localparam int unsigned FrameW   = 11;

   // Falling edges seen in SEND before the stop bit is on the wire.
   localparam logic [3:0] LastSendFe = 4'd9;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StSend,
      StAck,
      StWaitIdle
   } state_e;

   state_e              state_q, state_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [FrameW-1:0]   shift_q, shift_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   clk_prev_q;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fe;

   // Synchronise the keyboard lines; reset to 1 (released bus) so no false edge follows reset.
   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
      end else begin
         clk_sync_q[0] <= clock_key;
         dat_sync_q[0] <= data_key;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync_q[i] <= clk_sync_q[i-1];
            dat_sync_q[i] <= dat_sync_q[i-1];
         end
      end
   end

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];

   // Remember the previous synced clock to form a one-cycle falling-edge strobe.
   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         clk_prev_q <= 1'b1;
      end else begin
         clk_prev_q <= clk_s;
      end
   end

   assign fe = clk_prev_q & ~clk_s;

   // State, counters, frame shifter and the registered done/error pulses.
   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   // Next-state logic: request-to-send, bit shifting on device clock edges, ACK and timeout.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StInhibit;
               timer_d   = '0;
               bit_cnt_d = '0;
               shift_d   = {1'b1, ~^data_in, data_in, 1'b0};
            end
         end

         StInhibit: begin
            if (timer_q == InhibitLast) begin
               state_d = StReq;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         StReq: begin
            state_d = StSend;
            timer_d = '0;
         end

         StSend, StAck, StWaitIdle: begin
            // Timeout wins over any edge or ACK seen in the same cycle.
            if (timer_q == TimeoutLast) begin
               state_d = StIdle;
               error_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
               if (state_q == StSend) begin
                  if (fe) begin
                     shift_d   = {1'b1, shift_q[FrameW-1:1]};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     if (bit_cnt_q == LastSendFe) begin
                        state_d = StAck;
                     end
                  end
               end else if (state_q == StAck) begin
                  if (fe) begin
                     if (dat_s) begin
                        state_d = StIdle;
                        error_d = 1'b1;
                     end else begin
                        state_d = StWaitIdle;
                     end
                  end
               end else begin
                  if (clk_s && dat_s) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Pin enables come straight from state so an async reset releases the bus at once.
   always_comb begin
      busy         = (state_q != StIdle);
      clock_key_oe = (state_q == StInhibit) || (state_q == StReq);
      data_key_oe  = (state_q == StReq) || ((state_q == StSend) && !shift_q[0]);
      done         = done_q;
      error        = error_q;
   end

endmodule
